// File: rtl/imem_rom_sync.sv
// Synchronous instruction memory with registered read, stall hold and address checks.
// Define IMEM_LOAD_EN to add the boot-load stream port and LOAD state.
module imem_rom_sync #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 10,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] endereco,
  input  logic              req,
  input  logic              stall,
`ifdef IMEM_LOAD_EN
  input  logic              carga_valid,
  input  logic [DATA_W-1:0] carga_dado,
  input  logic              carga_fim,
  output logic              carga_ready,
`endif
  output logic [DATA_W-1:0] saida,
  output logic              valid,
  output logic              misaligned,
  output logic              fora_faixa,
  output logic              pronto
);

  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h00000013);

  typedef enum logic {
    LOAD,
    RUN
  } state_e;

`ifdef IMEM_LOAD_EN
  localparam state_e RESET_ST = LOAD;
`else
  localparam state_e RESET_ST = RUN;
`endif

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = NOP;
  end

  // Address decode; the array is only indexed when the word index is in range.
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  rd_ptr;
  logic              mis_w;
  logic              oor_w;
  logic [DATA_W-1:0] rd_word;

  assign idx     = endereco[ADDR_W-1:2];
  assign rd_ptr  = idx[CNT_W-1:0];
  assign mis_w   = |endereco[1:0];
  assign oor_w   = ({1'b0, idx} >= (IDX_W+1)'(DEPTH));
  assign rd_word = (mis_w || oor_w) ? NOP : mem[rd_ptr];

`ifdef IMEM_LOAD_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat;

  assign beat  = (state_q == LOAD) && carga_valid;
  assign cnt_d = beat ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n && beat) mem[cnt_q] <= carga_dado;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RESET_ST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef IMEM_LOAD_EN
    if (beat && (carga_fim || cnt_q == CNT_W'(DEPTH - 1))) state_d = RUN;
`else
    state_d = RUN;
`endif
  end

  always_comb begin
    pronto = (state_q == RUN);
`ifdef IMEM_LOAD_EN
    carga_ready = (state_q == LOAD);
`endif
  end

  logic [DATA_W-1:0] saida_q, saida_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;
  logic              oor_q, oor_d;

  always_comb begin
    saida_d = saida_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    oor_d   = oor_q;
    if (state_q == LOAD) begin
      valid_d = 1'b0;
      mis_d   = 1'b0;
      oor_d   = 1'b0;
    end else if (!stall) begin
      valid_d = req;
      mis_d   = req && mis_w;
      oor_d   = req && oor_w;
      if (req) saida_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      saida_q <= NOP;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      saida_q <= saida_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      oor_q   <= oor_d;
    end
  end

  assign saida      = saida_q;
  assign valid      = valid_q;
  assign misaligned = mis_q;
  assign fora_faixa = oor_q;

endmodule

// File: tb/tb_imem_rom_sync.sv
// Directed bench for imem_rom_sync; covers both IMEM_LOAD_EN builds.
module tb_imem_rom_sync;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n, req, stall;
  logic [9:0]  endereco;
  logic [31:0] saida;
  logic        valid, misaligned, fora_faixa, pronto;
`ifdef IMEM_LOAD_EN
  logic        carga_valid, carga_fim, carga_ready;
  logic [31:0] carga_dado;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  imem_rom_sync #(.DATA_W(32), .DEPTH(64), .ADDR_W(10), .INIT_FILE("")) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .endereco   (endereco),
    .req        (req),
    .stall      (stall),
`ifdef IMEM_LOAD_EN
    .carga_valid(carga_valid),
    .carga_dado (carga_dado),
    .carga_fim  (carga_fim),
    .carga_ready(carga_ready),
`endif
    .saida      (saida),
    .valid      (valid),
    .misaligned (misaligned),
    .fora_faixa (fora_faixa),
    .pronto     (pronto)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [9:0] a);
    req = 1'b1; endereco = a; step();
  endtask

  task automatic flags(input string tag, input logic v, input logic m, input logic f,
                       input logic [31:0] d);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
    chk({tag, ".mis"},   {31'd0, misaligned}, {31'd0, m});
    chk({tag, ".oor"},   {31'd0, fora_faixa}, {31'd0, f});
    chk({tag, ".saida"}, saida, d);
  endtask

`ifdef IMEM_LOAD_EN
  task automatic beat(input logic [31:0] d, input logic fim);
    carga_valid = 1'b1; carga_dado = d; carga_fim = fim; step();
    carga_valid = 1'b0; carga_fim = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; req = 1'b0; stall = 1'b0; endereco = '0;
`ifdef IMEM_LOAD_EN
    carga_valid = 1'b0; carga_fim = 1'b0; carga_dado = '0;
`endif
    step(); step();
    rst_n = 1'b1;
    flags("reset", 1'b0, 1'b0, 1'b0, NOP);

`ifdef IMEM_LOAD_EN
    chk("reset.pronto", {31'd0, pronto}, 32'd0);
    chk("reset.ready",  {31'd0, carga_ready}, 32'd1);

    // req during LOAD must be ignored
    req = 1'b1; endereco = 10'h000;
    beat(32'h00100093, 1'b0);
    chk("load1.valid",  {31'd0, valid}, 32'd0);
    chk("load1.pronto", {31'd0, pronto}, 32'd0);
    req = 1'b0;
    beat(32'h00200113, 1'b0);
    beat(32'h00300193, 1'b1);
    chk("load.pronto", {31'd0, pronto}, 32'd1);
    chk("load.ready",  {31'd0, carga_ready}, 32'd0);

    rd(10'h000); flags("rd0", 1'b1, 1'b0, 1'b0, 32'h00100093);
    rd(10'h004); flags("rd4", 1'b1, 1'b0, 1'b0, 32'h00200113);
    rd(10'h008); flags("rd8", 1'b1, 1'b0, 1'b0, 32'h00300193);
`else
    chk("reset.pronto", {31'd0, pronto}, 32'd1);
    rd(10'h000); flags("rd0", 1'b1, 1'b0, 1'b0, NOP);
    rd(10'h0FC); flags("rdFC", 1'b1, 1'b0, 1'b0, NOP);
`endif

    rd(10'h006); flags("mis", 1'b1, 1'b1, 1'b0, NOP);
    rd(10'h100); flags("oor", 1'b1, 1'b0, 1'b1, NOP);
    rd(10'h102); flags("both", 1'b1, 1'b1, 1'b1, NOP);
    req = 1'b0; step();
    flags("idle", 1'b0, 1'b0, 1'b0, NOP);

`ifdef IMEM_LOAD_EN
    rd(10'h004);
    stall = 1'b1; endereco = 10'h008;
    for (int i = 0; i < 3; i++) begin
      step(); flags("stall", 1'b1, 1'b0, 1'b0, 32'h00200113);
    end
    stall = 1'b0; step();
    flags("unstall", 1'b1, 1'b0, 1'b0, 32'h00300193);
    req = 1'b0;

    // full load with no carga_fim
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 63; i++) beat(i, 1'b0);
    chk("full63.pronto", {31'd0, pronto}, 32'd0);
    beat(32'd63, 1'b0);
    chk("full64.pronto", {31'd0, pronto}, 32'd1);
    carga_valid = 1'b1; carga_dado = 32'hDEADBEEF;
    chk("full65.ready", {31'd0, carga_ready}, 32'd0);
    step(); carga_valid = 1'b0;
    rd(10'h0FC); chk("full.rdFC", saida, 32'd63);
    rd(10'h000); chk("full.rd0",  saida, 32'd0);
    req = 1'b0;

    // reset in the middle of a load
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) beat(32'hA0 + i, 1'b0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst.pronto", {31'd0, pronto}, 32'd0);
    chk("midrst.ready",  {31'd0, carga_ready}, 32'd1);
    beat(32'h11111111, 1'b0);
    beat(32'h22222222, 1'b1);
    rd(10'h024); chk("mid.rd24", saida, 32'hA9);
    rd(10'h000); chk("mid.rd0",  saida, 32'h11111111);
    rd(10'h004); chk("mid.rd4",  saida, 32'h22222222);
    rd(10'h008); chk("mid.rd8",  saida, 32'hA2);
    req = 1'b0;
`else
    rd(10'h006);
    stall = 1'b1; endereco = 10'h100;
    for (int i = 0; i < 3; i++) begin
      step(); flags("stall", 1'b1, 1'b1, 1'b0, NOP);
    end
    stall = 1'b0; step();
    flags("unstall", 1'b1, 1'b0, 1'b1, NOP);
    req = 1'b0; stall = 1'b1; step();
    flags("stall_idle", 1'b1, 1'b0, 1'b1, NOP);
    stall = 1'b0; step();
    flags("idle2", 1'b0, 1'b0, 1'b0, NOP);
    rst_n = 1'b0; req = 1'b1; step(); rst_n = 1'b1; req = 1'b0;
    chk("rst_prio.valid", {31'd0, valid}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
